uptime_frame_tx: RTL and testbench

- Downstream consumer of the strobe generator bank.
- Counts seconds from the every_second strobe into a 32-bit uptime counter.
- On each send_data strobe, snapshots the counter and serialises a 5-byte frame over a UART line: sync byte 0xA5, then the 4 counter bytes MSB first.
- Provides the board's periodic telemetry output.

---
 rtl/uptime_frame_tx_pkg.sv | 32 +++
 rtl/uart_byte_tx.sv | 129 ++++++++++++
 rtl/uptime_frame_tx.sv | 105 ++++++++++
 tb/tb_uptime_frame_tx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uptime_frame_tx_pkg.sv
// Shared constants and FSM encoding for the uptime telemetry transmitter.
// Optional feature macro: UPTIME_TX_PARITY_EN (adds an even-parity bit per byte).
package uptime_frame_tx_pkg;

    // 100 MHz board clock / 115200 baud
    localparam int         CLKS_PER_BIT_DEF = 868;
    localparam logic [7:0] SYNC_BYTE_DEF    = 8'hA5;
    localparam int         CNT_W_DEF        = 32;

`ifdef UPTIME_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } tx_state_e;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;
`endif

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte UART serialiser: start bit, 8 data bits LSB first,
// optional even-parity bit (UPTIME_TX_PARITY_EN), one stop bit.
// A start request seen on the cycle the stop bit ends chains straight into
// the next start bit with no idle gap.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_IDLE   | line high, waiting for start
// ST_START  | driving the start bit (0)
// ST_DATA   | driving data bit bit_q
// ST_PARITY | driving the even-parity bit (parity build only)
// ST_STOP   | driving the stop bit (1); done pulses on its last cycle
module uart_byte_tx
    import uptime_frame_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       done
);

    localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    data_q, data_d;
    logic          tx_q, tx_d;
    logic          bit_end;

    // State, bit timer, data latch and line register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            tx_q    <= tx_d;
        end
    end

    // Next-state logic; tx only changes when the bit timer wraps
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        data_d  = data_q;
        tx_d    = tx_q;
        done    = 1'b0;
        bit_end = (cnt_q == CNT_LAST);

        if (state_q != ST_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    state_d = ST_START;
                    data_d  = data;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = ST_DATA;
                    bit_d   = '0;
                    tx_d    = data_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
`ifdef UPTIME_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = even_parity(data_q);
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = data_q[bit_q + 3'd1];
                    end
                end
            end
`ifdef UPTIME_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    done = 1'b1;
                    if (start) begin
                        state_d = ST_START;
                        data_d  = data;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    assign tx = tx_q;

endmodule

// File: rtl/uptime_frame_tx.sv
// Uptime telemetry transmitter: counts every_second strobes and, on each
// send_data strobe, sends SYNC_BYTE followed by the uptime snapshot MSB first.
// Optional feature macro: UPTIME_TX_PARITY_EN (8E1 framing instead of 8N1).
module uptime_frame_tx
    import uptime_frame_tx_pkg::*;
#(
    parameter int         CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter int         CNT_W        = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             every_second,
    input  logic             send_data,
    output logic             tx,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun,
    output logic [CNT_W-1:0] uptime
);

    localparam int            NBYTES   = CNT_W / 8;
    localparam int            IW       = $clog2(NBYTES + 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NBYTES);

    logic [CNT_W-1:0] uptime_q, uptime_d;
    logic [CNT_W-1:0] snap_q, snap_d;
    logic [IW-1:0]    byte_idx_q, byte_idx_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             overrun_q, overrun_d;

    logic             accept;
    logic             byte_start;
    logic [7:0]       byte_data;
    logic             byte_done;

    // Counter, snapshot, sequencer and status flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            uptime_q     <= '0;
            snap_q       <= '0;
            byte_idx_q   <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            uptime_q     <= uptime_d;
            snap_q       <= snap_d;
            byte_idx_q   <= byte_idx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            overrun_q    <= overrun_d;
        end
    end

    // Byte sequencer: the snapshot shifts left so the next payload byte is
    // always at the top; the frame_done cycle still counts as busy.
    always_comb begin
        uptime_d     = every_second ? uptime_q + CNT_W'(1) : uptime_q;
        snap_d       = snap_q;
        byte_idx_d   = byte_idx_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        byte_start   = 1'b0;
        byte_data    = SYNC_BYTE;

        accept    = send_data & ~busy_q & ~frame_done_q;
        overrun_d = send_data & (busy_q | frame_done_q);

        if (accept) begin
            busy_d     = 1'b1;
            byte_idx_d = '0;
            snap_d     = uptime_q;
            byte_start = 1'b1;
        end else if (byte_done) begin
            if (byte_idx_q != IDX_LAST) begin
                byte_start = 1'b1;
                byte_data  = snap_q[CNT_W-1 -: 8];
                snap_d     = snap_q << 8;
                byte_idx_d = byte_idx_q + 1'b1;
            end else begin
                busy_d       = 1'b0;
                frame_done_d = 1'b1;
            end
        end
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .clk  (clk),
        .rst  (rst),
        .start(byte_start),
        .data (byte_data),
        .tx   (tx),
        .done (byte_done)
    );

    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overrun    = overrun_q;
    assign uptime     = uptime_q;

endmodule

// File: tb/tb_uptime_frame_tx.sv
// Scoreboard bench for uptime_frame_tx: expected frame bytes are queued when
// send_data is driven and popped by a UART line decoder watching tx.
module tb_uptime_frame_tx;

    localparam int CPB = 4;
`ifdef UPTIME_TX_PARITY_EN
    localparam int BITS = 11;
`else
    localparam int BITS = 10;
`endif
    localparam int FRAME_CYC = 5 * BITS * CPB;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        every_second = 1'b0;
    logic        send_data = 1'b0;
    logic        tx, busy, frame_done, overrun;
    logic [31:0] uptime;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] model_up = 32'd0;

    int          busy_cyc = 0;
    int          fd_cnt = 0;
    int          ov_cnt = 0;

    bit          mon_act = 1'b0;
    int          mon_cnt = 0;
    int          mon_j = 0;
    logic [7:0]  rx_byte = 8'd0;
    logic        rx_par = 1'b0;
    logic [7:0]  exp_b = 8'd0;

    always #5 clk = ~clk;

    uptime_frame_tx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_BYTE   (8'hA5),
        .CNT_W       (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .every_second(every_second),
        .send_data   (send_data),
        .tx          (tx),
        .busy        (busy),
        .frame_done  (frame_done),
        .overrun     (overrun),
        .uptime      (uptime)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Status counters sampled mid-cycle
    always @(negedge clk) begin
        if (busy === 1'b1)       busy_cyc++;
        if (frame_done === 1'b1) fd_cnt++;
        if (overrun === 1'b1)    ov_cnt++;
    end

    // UART decoder: samples each bit in its middle and checks against the scoreboard
    always @(negedge clk) begin
        if (rst) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (tx === 1'b0) begin
                mon_act = 1'b1;
                mon_cnt = 0;
            end
        end else begin
            mon_cnt++;
            if ((mon_cnt % CPB) == (CPB / 2)) begin
                mon_j = mon_cnt / CPB;
                if (mon_j == 0) begin
                    chk("start_bit", 32'(tx), 32'd0);
                end else if (mon_j <= 8) begin
                    rx_byte[mon_j-1] = tx;
                end else if (mon_j == BITS - 1) begin
                    chk("stop_bit", 32'(tx), 32'd1);
                    chk("byte_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) begin
                        exp_b = exp_q.pop_front();
                        chk("rx_byte", 32'(rx_byte), 32'(exp_b));
`ifdef UPTIME_TX_PARITY_EN
                        chk("parity_bit", 32'(rx_par), 32'(^exp_b));
`endif
                    end
                    mon_act = 1'b0;
                end else begin
                    rx_par = tx;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_sec();
        every_second = 1'b1;
        tick(1);
        every_second = 1'b0;
        model_up = model_up + 32'd1;
    endtask

    task automatic push_frame(input logic [31:0] v);
        exp_q.push_back(8'hA5);
        exp_q.push_back(v[31:24]);
        exp_q.push_back(v[23:16]);
        exp_q.push_back(v[15:8]);
        exp_q.push_back(v[7:0]);
    endtask

    task automatic send_frame();
        push_frame(model_up);
        send_data = 1'b1;
        tick(1);
        send_data = 1'b0;
    endtask

    // Returns while frame_done is high (one cycle after its rising edge is visible)
    task automatic wait_frame(input string tag);
        int k;
        k = 0;
        while (frame_done !== 1'b1 && k < FRAME_CYC + 50) begin
            tick(1);
            k++;
        end
        chk({tag, "_frame_done_seen"}, 32'(frame_done === 1'b1), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fd0;

        // 1: reset values, three seconds, one frame A5 00 00 00 03
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        chk("rst_uptime", uptime, 32'd0);
        repeat (3) pulse_sec();
        chk("uptime_after_3", uptime, model_up);
        busy_cyc = 0;
        fd_cnt = 0;
        send_frame();
        chk("busy_on_start", 32'(busy), 32'd1);
        chk("tx_start_bit_reg", 32'(tx), 32'd0);
        wait_frame("s1");
        chk("s1_busy_low_with_done", 32'(busy), 32'd0);
        tick(2);
        chk("s1_busy_cycles", 32'(busy_cyc), 32'(FRAME_CYC));
        chk("s1_frame_done_count", 32'(fd_cnt), 32'd1);
        chk("s1_queue_empty", 32'(exp_q.size()), 32'd0);

        // 2: wrap from all-ones to zero, zero payload
        force dut.uptime_q = 32'hFFFF_FFFF;
        tick(1);
        release dut.uptime_q;
        model_up = 32'hFFFF_FFFF;
        tick(1);
        chk("preload_uptime", uptime, model_up);
        pulse_sec();
        chk("wrap_uptime", uptime, 32'd0);
        send_frame();
        wait_frame("s2");
        tick(2);
        chk("s2_queue_empty", 32'(exp_q.size()), 32'd0);

        // 3: every_second coincident with send_data at uptime 7
        repeat (7) pulse_sec();
        chk("uptime_7", uptime, 32'd7);
        push_frame(model_up);
        every_second = 1'b1;
        send_data = 1'b1;
        tick(1);
        every_second = 1'b0;
        send_data = 1'b0;
        model_up = model_up + 32'd1;
        chk("coincident_uptime", uptime, 32'd8);
        wait_frame("s3");
        tick(2);
        chk("s3_queue_empty", 32'(exp_q.size()), 32'd0);

        // 4: send_data mid-frame and on the frame_done cycle both give overrun
        ov_cnt = 0;
        fd0 = fd_cnt;
        send_frame();
        tick(50);
        send_data = 1'b1;
        tick(1);
        send_data = 1'b0;
        chk("ovr_pulse_now", 32'(overrun), 32'd1);
        tick(1);
        chk("ovr_pulse_width", 32'(overrun), 32'd0);
        chk("ovr_count_mid", 32'(ov_cnt), 32'd1);
        chk("ovr_busy_kept", 32'(busy), 32'd1);
        wait_frame("s4");
        send_data = 1'b1;
        tick(1);
        send_data = 1'b0;
        tick(2);
        chk("ovr_count_at_done", 32'(ov_cnt), 32'd2);
        chk("ovr_no_restart_busy", 32'(busy), 32'd0);
        tick(FRAME_CYC);
        chk("s4_frame_count", 32'(fd_cnt - fd0), 32'd1);
        chk("s4_tx_idle", 32'(tx), 32'd1);
        chk("s4_queue_empty", 32'(exp_q.size()), 32'd0);

        // 5: reset during byte 2 abandons the frame
        send_frame();
        tick(2 * BITS * CPB + 10);
        fd0 = fd_cnt;
        rst = 1'b1;
        #1;
        chk("midrst_tx", 32'(tx), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        tick(2);
        rst = 1'b0;
        exp_q.delete();
        model_up = 32'd0;
        tick(2);
        chk("midrst_no_frame_done", 32'(fd_cnt - fd0), 32'd0);
        chk("midrst_uptime", uptime, 32'd0);
        send_frame();
        wait_frame("s5");
        tick(2);
        chk("s5_queue_empty", 32'(exp_q.size()), 32'd0);

        // 6: uptime 1 frame; length and parity depend on the build
        pulse_sec();
        busy_cyc = 0;
        send_frame();
        wait_frame("s6");
        tick(2);
        chk("s6_busy_cycles", 32'(busy_cyc), 32'(FRAME_CYC));
        chk("s6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
